rc4_ksa: RTL and testbench

//  RC4 key-scheduling stage. Runs after the S-box RAM has been filled with the identity
//  (S[i]=i). For i=0..255 it computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] and S[j].
//  It drives the shared single-port 256x8 S RAM (1-cycle read latency) through the top-level mux.
//  It hands off to the PRGA/decrypt stage using the same start/done/done_ack handshake as the init stage.

---
 rtl/rc4_pkg.sv | 32 +++
 rtl/rc4_ksa.sv | 117 +++++++++++
 tb/tb_rc4_ksa.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the S-box init, key-scheduling and decrypt stages.
package rc4_pkg;

    localparam int RC4_N             = 256;
    localparam int RC4_AW            = 8;
    localparam int RC4_MAX_KEY_BYTES = 32;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LD_I,
        RD_J,
        LD_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // Key byte k of a key_bytes-long key, MSB first, held right-aligned in key.
    function automatic byte_t key_byte(input logic [RC4_MAX_KEY_BYTES*8-1:0] key,
                                       input int key_bytes,
                                       input byte_t k);
        key_byte = '0;
        for (int b = 0; b < RC4_MAX_KEY_BYTES; b++) begin
            if (b == key_bytes - 1 - int'(k))
                key_byte = key[b*8 +: 8];
        end
    endfunction

endpackage

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage: permutes the identity S-box in the shared single-port RAM
// using the latched key, six cycles per index, then waits for downstream acknowledge.
module rc4_ksa
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   done_ack,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    output logic [RC4_AW-1:0]      mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_rdata,
    output logic                   busy,
    output logic                   ksa_done
);

    ksa_state_t             state;
    byte_t                  i, j, k;
    byte_t                  si;
    logic [KEY_BYTES*8-1:0] key_q;

    logic [RC4_MAX_KEY_BYTES*8-1:0] key_ext;
    byte_t                          j_next;
    logic                           last_iter;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        key_ext                  = '0;
        key_ext[KEY_BYTES*8-1:0] = key_q;
    end

    assign j_next    = j + mem_rdata + key_byte(key_ext, KEY_BYTES, k);
    assign last_iter = (i == byte_t'(RC4_N - 1));

    // Outputs are registered: each branch loads the values the *next* state presents.
    // mem_wdata doubles as the S[j] holding register during WR_I.
    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            key_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            busy      <= 1'b0;
            ksa_done  <= 1'b0;
        end else begin
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            mem_addr  <= i;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RD_I;
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        key_q    <= secret_key;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                RD_I: state <= LD_I;
                LD_I: begin
                    si       <= mem_rdata;
                    j        <= j_next;
                    mem_addr <= j_next;
                    state    <= RD_J;
                end
                RD_J: state <= LD_J;
                LD_J: begin
                    mem_wdata <= mem_rdata;
                    mem_wren  <= 1'b1;
                    state     <= WR_I;
                end
                WR_I: begin
                    mem_addr  <= j;
                    mem_wdata <= si;
                    mem_wren  <= 1'b1;
                    state     <= WR_J;
                end
                WR_J: begin
                    if (last_iter) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        ksa_done <= 1'b1;
                    end else begin
                        i        <= i + 1'b1;
                        k        <= (k == byte_t'(KEY_BYTES - 1)) ? '0 : k + 1'b1;
                        mem_addr <= i + 1'b1;
                        state    <= RD_I;
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        state    <= IDLE;
                        ksa_done <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ksa_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa.sv
// Self-checking bench for rc4_ksa: behavioural 256x8 S RAM, hand-computed vectors
// for the first iterations and a software RC4 KSA model for full runs.
module tb_rc4_ksa;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        done_ack;
    logic [23:0] secret_key;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        ksa_done;

    rc4_ksa #(.KEY_BYTES(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .done_ack   (done_ack),
        .secret_key (secret_key),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren   (mem_wren),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .ksa_done   (ksa_done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic       ram_init = 1'b0;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 256; a++) ram[a] <= 8'(a);
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int since_start = 0;
    int wren_seen = 0;
    logic [7:0] model_s [256];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        if (mem_wren) wren_seen++;
        @(posedge clk);
        #1;
        since_start++;
    endtask

    task automatic init_ram();
        ram_init = 1'b1;
        @(posedge clk);
        #1;
        ram_init = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] key);
        secret_key = key;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        since_start = 0;
        wren_seen   = 0;
    endtask

    task automatic wait_done();
        while (!ksa_done && since_start < 2000) tick();
    endtask

    task automatic compute_model(input logic [23:0] key);
        int         jm;
        logic [7:0] kb [3];
        logic [7:0] t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
        jm = 0;
        for (int a = 0; a < 256; a++) begin
            jm = (jm + int'(model_s[a]) + int'(kb[a % 3])) % 256;
            t = model_s[a];
            model_s[a] = model_s[jm];
            model_s[jm] = t;
        end
    endtask

    task automatic compare_s(input string name);
        int mism = 0;
        int dup  = 0;
        int seen [256];
        for (int a = 0; a < 256; a++) seen[a] = 0;
        for (int a = 0; a < 256; a++) begin
            if (ram[a] !== model_s[a]) mism++;
            seen[ram[a]]++;
        end
        for (int a = 0; a < 256; a++) if (seen[a] != 1) dup++;
        check({name, "_s_mismatches"}, mism, 0);
        check({name, "_not_permutation"}, dup, 0);
    endtask

    typedef struct {
        int iter;
        int addr;
        int exp;
    } s_vec_t;

    s_vec_t tbl [7];

    initial begin
        int w0;
        int bad;

        // Key 0: j = 0,1,3 for i = 0..2 (S becomes 0,1,3,2,...); at i=3 S[3] already
        // holds 2, so j = 5 and S[3],S[5] swap to 5,2.
        tbl[0] = '{iter: 2, addr: 0, exp: 0};
        tbl[1] = '{iter: 2, addr: 1, exp: 1};
        tbl[2] = '{iter: 2, addr: 2, exp: 3};
        tbl[3] = '{iter: 2, addr: 3, exp: 2};
        tbl[4] = '{iter: 2, addr: 5, exp: 5};
        tbl[5] = '{iter: 3, addr: 3, exp: 5};
        tbl[6] = '{iter: 3, addr: 5, exp: 2};

        reset_n    = 1'b0;
        start      = 1'b0;
        done_ack   = 1'b0;
        secret_key = 24'h0;
        init_ram();
        @(posedge clk);
        #1;
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_mem_wren", int'(mem_wren), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ksa_done", int'(ksa_done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // done_ack in IDLE is ignored.
        @(posedge clk);
        #1;
        done_ack = 1'b1;
        tick();
        tick();
        done_ack = 1'b0;
        check("idle_ack_busy", int'(busy), 0);
        check("idle_ack_done", int'(ksa_done), 0);

        // Test 1: first iterations with the all-zero key.
        init_ram();
        start_run(24'h000000);
        for (int e = 0; e < 7; e++) begin
            while (since_start < 6 * (tbl[e].iter + 1)) tick();
            check($sformatf("t1_it%0d_s%0d", tbl[e].iter, tbl[e].addr),
                  int'(ram[tbl[e].addr]), tbl[e].exp);
        end
        wait_done();
        check("t1_latency", since_start, 1536);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;

        // Tests 2/3: full run, latency and write count.
        init_ram();
        compute_model(24'h000249);
        start_run(24'h000249);
        check("t3_busy_after_accept", int'(busy), 1);
        check("t3_addr_after_accept", int'(mem_addr), 0);
        wait_done();
        check("t3_latency", since_start, 1536);
        check("t3_wren_cycles", wren_seen, 512);
        check("t3_busy_in_done", int'(busy), 0);
        compare_s("t2");

        // Test 4: DONE holds until done_ack; start together with done_ack only returns to IDLE.
        w0  = wren_seen;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!ksa_done || busy) bad++;
        end
        check("t4_done_held", bad, 0);
        check("t4_no_wren_in_done", wren_seen - w0, 0);
        start    = 1'b1;
        done_ack = 1'b1;
        tick();
        start    = 1'b0;
        done_ack = 1'b0;
        check("t4_ack_clears_done", int'(ksa_done), 0);
        check("t4_ack_not_busy", int'(busy), 0);
        tick();
        check("t4_stays_idle", int'(busy), 0);

        // Test 5: asynchronous reset in the WR_I cycle of iteration 100.
        init_ram();
        start_run(24'h000249);
        while (since_start < 604) tick();
        check("t5_pre_wren", int'(mem_wren), 1);
        check("t5_pre_addr", int'(mem_addr), 100);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_mem_addr", int'(mem_addr), 0);
        check("t5_rst_mem_wdata", int'(mem_wdata), 0);
        check("t5_rst_mem_wren", int'(mem_wren), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_ksa_done", int'(ksa_done), 0);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        init_ram();
        start_run(24'h000249);
        wait_done();
        check("t5_latency", since_start, 1536);
        compare_s("t5");
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;

        // Test 6: start, done_ack and secret_key disturbed mid-run.
        init_ram();
        compute_model(24'h1A2B3C);
        start_run(24'h1A2B3C);
        while (since_start < 300) tick();
        secret_key = 24'hFFFFFF;
        done_ack   = 1'b1;
        for (int c = 0; c < 12; c++) begin
            start = ~start;
            tick();
        end
        start    = 1'b0;
        done_ack = 1'b0;
        check("t6_still_busy", int'(busy), 1);
        wait_done();
        check("t6_latency", since_start, 1536);
        check("t6_wren_cycles", wren_seen, 512);
        compare_s("t6");
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check("t6_back_idle", int'(ksa_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
